// File: rtl/btn_cmd_pkg.sv
// Shared definitions for the front-panel button command scheduler.
// Command codes are also decoded by the mode/edit/timer FSM.
package btn_cmd_pkg;

    localparam int NUM_BTN = 5;

    // Command codes carried on cmd_code (6 and 7 are never driven)
    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_CLR   = 3'd1;
    localparam logic [2:0] CMD_MODE  = 3'd2;
    localparam logic [2:0] CMD_SHIFT = 3'd3;
    localparam logic [2:0] CMD_INC   = 3'd4;
    localparam logic [2:0] CMD_STST  = 3'd5;

    // Button bit positions in the synchronized vector, highest priority first
    localparam int BTN_RESET = 0;
    localparam int BTN_MODE  = 1;
    localparam int BTN_SHIFT = 2;
    localparam int BTN_INC   = 3;
    localparam int BTN_STST  = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUALIFY  = 2'd1,
        ST_FIRE     = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    // Bit position order matches code order, so the code is index+1
    function automatic logic [2:0] btn_to_cmd(input int idx);
        return 3'(idx + 1);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Parameterized-width two-flop synchronizer, synchronous active-high reset.
module btn_sync #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two register stages to resolve metastability on the raw inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/btn_cmd_sched.sv
// Front-panel button scheduler: synchronizes five buttons, picks one by fixed
// priority, qualifies it with a hold time and issues one command per press
// over a valid/ready handshake.
// Optional build macro BTN_CMD_AUTOREPEAT_EN: a held INC button re-fires every
// REPEAT_CYCLES (plus handshake latency) while it stays the only button held.
module btn_cmd_sched
    import btn_cmd_pkg::*;
#(
    parameter int HOLD_CYCLES   = 15_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CW = $clog2(((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_edit_shift,
    input  logic       i_btn_inc,
    input  logic       i_btn_start_stop,
    output logic       o_cmd_valid,
    output logic [2:0] o_cmd_code,
    input  logic       i_cmd_ready,
    output logic       o_busy
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef BTN_CMD_AUTOREPEAT_EN
    localparam logic [CW-1:0]      RPT_LAST = CW'(REPEAT_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] INC_ONLY = NUM_BTN'(1) << BTN_INC;
    logic r_rpt_stop;
`endif

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_s;
    logic [2:0]         w_win_code;
    logic               w_own_hi;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_owner;
    logic               r_cmd_valid;
    logic [2:0]         r_cmd_code;

    assign w_raw[BTN_RESET] = i_btn_reset;
    assign w_raw[BTN_MODE]  = i_btn_mode;
    assign w_raw[BTN_SHIFT] = i_btn_edit_shift;
    assign w_raw[BTN_INC]   = i_btn_inc;
    assign w_raw[BTN_STST]  = i_btn_start_stop;

    btn_sync #(.W(NUM_BTN)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_raw),
        .o_q   (w_s)
    );

    // Fixed-priority pick: scan low priority first so the highest one wins
    always_comb begin
        w_win_code = CMD_NONE;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_s[i]) w_win_code = btn_to_cmd(i);
        end
    end

    // Level of the button that currently owns the scheduler
    always_comb begin
        w_own_hi = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (r_owner == btn_to_cmd(i)) w_own_hi = w_s[i];
        end
    end

    // Scheduler FSM with registered command outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_owner     <= CMD_NONE;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= CMD_NONE;
`ifdef BTN_CMD_AUTOREPEAT_EN
            r_rpt_stop  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_code != CMD_NONE) begin
                        r_owner <= w_win_code;
                        r_cnt   <= '0;
                        r_state <= ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (!w_own_hi) begin
                        r_owner <= CMD_NONE;
                        r_state <= ST_IDLE;
                    end else if (r_cnt >= HOLD_LAST) begin
                        r_state <= ST_FIRE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIRE: begin
                    // Present the command one cycle after entry, hold until accepted
                    if (!r_cmd_valid) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_code  <= r_owner;
                    end else if (i_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd_code  <= CMD_NONE;
                        r_state     <= ST_WAIT_REL;
`ifdef BTN_CMD_AUTOREPEAT_EN
                        // Starting at 1 makes the period REPEAT_CYCLES + handshake
                        r_cnt       <= CW'(1);
`else
                        r_cnt       <= '0;
`endif
                    end
                end
                ST_WAIT_REL: begin
                    if (w_s == '0) begin
                        r_owner <= CMD_NONE;
                        r_state <= ST_IDLE;
`ifdef BTN_CMD_AUTOREPEAT_EN
                        r_rpt_stop <= 1'b0;
                    end else if (!r_rpt_stop && r_owner == CMD_INC && w_s == INC_ONLY) begin
                        if (r_cnt >= RPT_LAST) r_state <= ST_FIRE;
                        else                   r_cnt   <= r_cnt + 1'b1;
                    end else begin
                        // Any other button or an INC release ends repeating for this press
                        r_rpt_stop <= 1'b1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_code  = r_cmd_code;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_btn_cmd_sched.sv
// Directed testbench for btn_cmd_sched (HOLD_CYCLES=4, REPEAT_CYCLES=3).
module tb_btn_cmd_sched;

    localparam int HOLD = 4;
    localparam int RPT  = 3;
    localparam int WIN  = 40;
`ifdef BTN_CMD_AUTOREPEAT_EN
    localparam int INC_N    = 4;
    localparam int INC_LAST = 19;
`else
    localparam int INC_N    = 1;
    localparam int INC_LAST = 7;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn = '0;   // [0]=reset [1]=mode [2]=shift [3]=inc [4]=start_stop
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    btn_cmd_sched #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_btn_reset      (btn[0]),
        .i_btn_mode       (btn[1]),
        .i_btn_edit_shift (btn[2]),
        .i_btn_inc        (btn[3]),
        .i_btn_start_stop (btn[4]),
        .o_cmd_valid      (cmd_valid),
        .o_cmd_code       (cmd_code),
        .i_cmd_ready      (cmd_ready),
        .o_busy           (busy)
    );

    typedef struct {
        logic [4:0] btn;
        int         hold;
        int         code;
        int         npulse;
        int         first;
        int         last;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Index of the first posedge after which cmd_valid is seen, -1 on timeout
    task automatic wait_valid(output int k);
        k = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cmd_valid) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int b);
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            tick();
        end
        b = busy;
    endtask

    initial begin
        int first, last, npulse, code, idle_bad, b, k, unstable;

        //            btn       hold code  n      first last
        tbl[0] = '{5'b00010, 20, 2, 1,     7,  7};        // mode held
        tbl[1] = '{5'b01000,  3, 0, 0,    -1, -1};        // short inc press
        tbl[2] = '{5'b01001, 20, 1, 1,     7,  7};        // inc + reset together
        tbl[3] = '{5'b00100, 10, 3, 1,     7,  7};        // edit shift
        tbl[4] = '{5'b10000,  8, 5, 1,     7,  7};        // start/stop
        tbl[5] = '{5'b01000,  4, 0, 0,    -1, -1};        // one cycle too short
        tbl[6] = '{5'b01000,  5, 4, 1,     7,  7};        // just long enough
        tbl[7] = '{5'b01000, 20, 4, INC_N, 7, INC_LAST};  // long inc hold
        tbl[8] = '{5'b00010, 30, 2, 1,     7,  7};        // long mode hold

        repeat (3) tick();
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_code", int'(cmd_code), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            first = -1; last = -1; npulse = 0; code = 0; idle_bad = 0;
            btn = tbl[v].btn;
            for (int i = 0; i < WIN; i++) begin
                tick();
                if (cmd_valid) begin
                    if (first < 0) first = i;
                    last = i;
                    npulse++;
                    code = int'(cmd_code);
                end else if (cmd_code != 3'd0) begin
                    idle_bad++;
                end
                if (i == tbl[v].hold - 1) btn = '0;
            end
            wait_idle(b);
            chk($sformatf("v%0d_first", v), first, tbl[v].first);
            chk($sformatf("v%0d_last", v), last, tbl[v].last);
            chk($sformatf("v%0d_npulse", v), npulse, tbl[v].npulse);
            chk($sformatf("v%0d_code", v), code, tbl[v].code);
            chk($sformatf("v%0d_idle_code", v), idle_bad, 0);
            chk($sformatf("v%0d_busy_end", v), b, 0);
            tick();
        end

        // Back-pressure: command held stable while ready is low, owner released
        cmd_ready = 1'b0;
        btn = 5'b10000;
        wait_valid(k);
        chk("bp_latency", k, 7);
        btn = '0;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!cmd_valid || cmd_code != 3'd5) unstable++;
        end
        chk("bp_stable", unstable, 0);
        cmd_ready = 1'b1;
        tick();
        chk("bp_hs_valid", int'(cmd_valid), 0);
        chk("bp_hs_code", int'(cmd_code), 0);
        wait_idle(b);
        chk("bp_busy_end", b, 0);
        tick();

        // Module reset while a command is pending
        cmd_ready = 1'b0;
        btn = 5'b00010;
        wait_valid(k);
        chk("mr_pending", k, 7);
        reset = 1'b1;
        tick();
        chk("mr_valid", int'(cmd_valid), 0);
        chk("mr_code", int'(cmd_code), 0);
        chk("mr_busy", int'(busy), 0);
        reset = 1'b0;
        btn = '0;
        cmd_ready = 1'b1;
        repeat (4) tick();
        btn = 5'b00010;
        wait_valid(k);
        chk("mr_refire_lat", k, 7);
        chk("mr_refire_code", int'(cmd_code), 2);
        btn = '0;
        wait_idle(b);
        chk("mr_busy_end", b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
